// File: rtl/m_64spi.sv
// m_64spi: SPI mode-0 master running one full-duplex 64-bit MSB-first frame per start.
// A single shift register sends from its MSB and collects synchronized MISO into its LSB.
module m_64spi #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] tx_data,
  output logic [63:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  div_reg, div_next;
  logic [6:0]  tog_reg, tog_next;
  logic [63:0] shift_reg, shift_next;
  logic [63:0] rx_reg, rx_next;
  logic        sclk_reg, sclk_next;
  logic        mosi_reg, mosi_next;
  logic        ss_reg, ss_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        miso_meta_reg, miso_sync_reg;
  logic        div_end;

  assign div_end = (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso_meta_reg <= 1'b0;
      miso_sync_reg <= 1'b0;
    end else begin
      miso_meta_reg <= MISO;
      miso_sync_reg <= miso_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      div_reg   <= 8'd0;
      tog_reg   <= 7'd0;
      shift_reg <= 64'd0;
      rx_reg    <= 64'd0;
      sclk_reg  <= 1'b0;
      mosi_reg  <= 1'b0;
      ss_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      tog_reg   <= tog_next;
      shift_reg <= shift_next;
      rx_reg    <= rx_next;
      sclk_reg  <= sclk_next;
      mosi_reg  <= mosi_next;
      ss_reg    <= ss_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    tog_next   = tog_reg;
    shift_next = shift_reg;
    rx_next    = rx_reg;
    sclk_next  = sclk_reg;
    mosi_next  = mosi_reg;
    ss_next    = ss_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = tx_data;
          mosi_next  = tx_data[63];
          ss_next    = 1'b0;
          busy_next  = 1'b1;
          div_next   = 8'd0;
          tog_next   = 7'd0;
          state_next = SETUP;
        end
      end

      SETUP: begin
        // Leaving SETUP produces the first SCLK rise, so it counts as toggle one.
        if (div_end) begin
          div_next   = 8'd0;
          sclk_next  = 1'b1;
          tog_next   = tog_reg + 7'd1;
          state_next = XFER;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      XFER: begin
        if (div_end) begin
          div_next  = 8'd0;
          sclk_next = ~sclk_reg;
          tog_next  = tog_reg + 7'd1;
          if (sclk_reg) begin
            shift_next = {shift_reg[62:0], miso_sync_reg};
            // The last fall leaves MOSI on the final bit.
            if (tog_reg != 7'd127) begin
              mosi_next = shift_reg[62];
            end
          end
          if (tog_reg == 7'd127) begin
            state_next = HOLD;
          end
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      HOLD: begin
        if (div_end) begin
          div_next   = 8'd0;
          ss_next    = 1'b1;
          state_next = GAP;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      GAP: begin
        if (div_end) begin
          div_next   = 8'd0;
          rx_next    = shift_reg;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data = rx_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign SCLK    = sclk_reg;
  assign MOSI    = mosi_reg;
  assign SS      = ss_reg;

endmodule

// File: tb/tb_m_64spi.sv
// Bench for m_64spi: three instances (CLK_DIV 4, 8, 255), loopback or a behavioural
// mode-0 slave on instance 0, and a queue of expected rx_data popped on every done.
module tb_m_64spi;

  localparam logic [23:0] DIVS = {8'd255, 8'd8, 8'd4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_s, start_s, busy_s, done_s, sclk_s, mosi_s, miso_s, ss_s;
  logic [2:0][63:0] tx_s, rx_s;

  logic        loop0 = 1'b1;
  logic [63:0] slave_word = 64'd0;
  logic [63:0] slave_sh = 64'd0;
  logic [63:0] slave_rx = 64'd0;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [63:0] tx;
    logic        loop;
    logic [63:0] slave_word;
    logic [63:0] exp_rx;
    logic [63:0] exp_slave;
  } vec_t;

  vec_t vecs[5];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    m_64spi #(.CLK_DIV(int'(DIVS[gi*8 +: 8]))) u_dut (
      .clk     (clk),
      .reset   (rst_s[gi]),
      .start   (start_s[gi]),
      .tx_data (tx_s[gi]),
      .rx_data (rx_s[gi]),
      .busy    (busy_s[gi]),
      .done    (done_s[gi]),
      .SCLK    (sclk_s[gi]),
      .MOSI    (mosi_s[gi]),
      .MISO    (miso_s[gi]),
      .SS      (ss_s[gi])
    );
  end

  assign miso_s[0]   = loop0 ? mosi_s[0] : slave_sh[63];
  assign miso_s[2:1] = mosi_s[2:1];

  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: loads on SS fall, records MOSI on rises, shifts out on falls.
  always @(ss_s[0] or sclk_s[0]) begin
    if (!ss_s[0] && ss_prev) begin
      slave_sh = slave_word;
      slave_rx = 64'd0;
    end else if (!ss_s[0] && sclk_s[0] && !sclk_prev) begin
      slave_rx = {slave_rx[62:0], mosi_s[0]};
    end else if (!ss_s[0] && !sclk_s[0] && sclk_prev) begin
      slave_sh = {slave_sh[62:0], 1'b0};
    end
    ss_prev   = ss_s[0];
    sclk_prev = sclk_s[0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int id);
    logic [63:0] e;
    check("sb_expected_pending", 64'(exp_q.size() > 0), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_rx_data", rx_s[id], e);
    end
  endtask

  task automatic run_frame(input int id, input int cd, input logic [63:0] tx,
                           input logic [63:0] exp_rx, input logic [63:0] exp_slave,
                           input logic chk_slave);
    int e0, rises, ss_rise, last_r, last_f, ph, hi_min, hi_max, lo_min, lo_max;
    logic prev_sclk, prev_ss, got;
    @(negedge clk);
    start_s[id] = 1'b1;
    tx_s[id]    = tx;
    e0          = cyc + 1;
    exp_q.push_back(exp_rx);
    @(negedge clk);
    start_s[id] = 1'b0;
    check("accept_busy", 64'(busy_s[id]), 64'(1));
    check("accept_ss", 64'(ss_s[id]), 64'(0));
    check("accept_mosi", 64'(mosi_s[id]), 64'(tx[63]));
    rises = 0; ss_rise = -1; last_r = 0; last_f = -1;
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
    prev_sclk = sclk_s[id]; prev_ss = ss_s[id]; got = 1'b0;
    for (int n = 0; n < 140 * cd + 20 && !got; n++) begin
      @(negedge clk);
      if (sclk_s[id] && !prev_sclk) begin
        rises++;
        if (last_f >= 0) begin
          ph = cyc - last_f;
          if (ph < lo_min) lo_min = ph;
          if (ph > lo_max) lo_max = ph;
        end
        last_r = cyc;
      end
      if (!sclk_s[id] && prev_sclk) begin
        ph = cyc - last_r;
        if (ph < hi_min) hi_min = ph;
        if (ph > hi_max) hi_max = ph;
        last_f = cyc;
      end
      if (ss_s[id] && !prev_ss && ss_rise < 0) ss_rise = cyc;
      prev_sclk = sclk_s[id];
      prev_ss   = ss_s[id];
      if (done_s[id]) got = 1'b1;
    end
    check("frame_done_seen", 64'(got), 64'(1));
    if (got) begin
      sb_pop(id);
      check("done_time", 64'(cyc - e0), 64'(130 * cd));
      check("ss_rise_time", 64'(ss_rise - e0), 64'(129 * cd));
      check("sclk_rises", 64'(rises), 64'(64));
      check("sclk_high_min", 64'(hi_min), 64'(cd));
      check("sclk_high_max", 64'(hi_max), 64'(cd));
      check("sclk_low_min", 64'(lo_min), 64'(cd));
      check("sclk_low_max", 64'(lo_max), 64'(cd));
      check("done_busy_low", 64'(busy_s[id]), 64'(0));
      if (chk_slave) check("slave_rx", slave_rx, exp_slave);
    end
    $display("frame id=%0d cd=%0d tx=%h rx=%h done_at=E%0d", id, cd, tx, rx_s[id], cyc - e0);
    @(negedge clk);
    check("done_width", 64'(done_s[id]), 64'(0));
  endtask

  initial begin
    int e0, dones, done_at, extra, falls, rise1, fall2, done_hi, done_edges;
    logic prev_ss, prev_done;

    vecs[0] = '{64'hA5A5_0F0F_1234_5678, 1'b1, 64'd0, 64'hA5A5_0F0F_1234_5678, 64'hA5A5_0F0F_1234_5678};
    vecs[1] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h3333_3333_6666_6666, 64'h3333_3333_6666_6666, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{64'h0000_0000_0000_0000, 1'b1, 64'd0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF};

    rst_s   = 3'b000;
    start_s = 3'b000;
    tx_s    = '0;
    repeat (3) @(negedge clk);
    check("reset_ss", 64'(ss_s), 64'(3'b111));
    check("reset_sclk", 64'(sclk_s), 64'(0));
    check("reset_mosi", 64'(mosi_s), 64'(0));
    check("reset_busy", 64'(busy_s), 64'(0));
    check("reset_done", 64'(done_s), 64'(0));
    check("reset_rx0", rx_s[0], 64'd0);
    rst_s = 3'b111;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      loop0      = vecs[i].loop;
      slave_word = vecs[i].slave_word;
      run_frame(0, 4, vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_slave, 1'b1);
    end
    loop0 = 1'b1;

    // Busy lockout: new tx_data at E5, start pulses at E10 and E300.
    @(negedge clk);
    start_s[0] = 1'b1;
    tx_s[0]    = 64'h1357_9BDF_2468_ACE0;
    e0         = cyc + 1;
    exp_q.push_back(64'h1357_9BDF_2468_ACE0);
    @(negedge clk);
    start_s[0] = 1'b0;
    dones = 0; done_at = -1;
    for (int n = 0; n < 1300; n++) begin
      @(negedge clk);
      if (cyc == e0 + 4) tx_s[0] = 64'hFFFF_0000_FFFF_0000;
      start_s[0] = (cyc == e0 + 9) || (cyc == e0 + 299);
      if (done_s[0]) begin
        dones++;
        if (dones == 1) done_at = cyc - e0;
        sb_pop(0);
      end
    end
    start_s[0] = 1'b0;
    check("lockout_done_count", 64'(dones), 64'(1));
    check("lockout_done_time", 64'(done_at), 64'(520));
    check("lockout_idle_ss", 64'(ss_s[0]), 64'(1));
    $display("lockout id=0 dones=%0d rx=%h", dones, rx_s[0]);

    // Reset in the middle of XFER.
    @(negedge clk);
    start_s[0] = 1'b1;
    tx_s[0]    = 64'h0F0F_F0F0_5555_AAAA;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (200) @(negedge clk);
    check("midframe_busy", 64'(busy_s[0]), 64'(1));
    rst_s[0] = 1'b0;
    #1;
    check("midrst_ss", 64'(ss_s[0]), 64'(1));
    check("midrst_sclk", 64'(sclk_s[0]), 64'(0));
    check("midrst_mosi", 64'(mosi_s[0]), 64'(0));
    check("midrst_busy", 64'(busy_s[0]), 64'(0));
    check("midrst_done", 64'(done_s[0]), 64'(0));
    check("midrst_rx", rx_s[0], 64'd0);
    extra = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_s[0]) extra++;
    end
    rst_s[0] = 1'b1;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (done_s[0]) extra++;
    end
    check("midrst_no_done", 64'(extra), 64'(0));
    check("midrst_rx_after", rx_s[0], 64'd0);
    $display("midreset id=0 extra_done=%0d rx=%h", extra, rx_s[0]);

    // Back-to-back frames on the CLK_DIV=8 instance with start held high.
    @(negedge clk);
    start_s[1] = 1'b1;
    tx_s[1]    = 64'hFEDC_BA98_7654_3210;
    exp_q.push_back(64'hFEDC_BA98_7654_3210);
    exp_q.push_back(64'h0F1E_2D3C_4B5A_6978);
    @(negedge clk);
    tx_s[1] = 64'h0F1E_2D3C_4B5A_6978;
    prev_ss = ss_s[1]; prev_done = 1'b0;
    falls = (ss_s[1] == 1'b0) ? 1 : 0;
    rise1 = -1; fall2 = -1; done_hi = 0; done_edges = 0;
    for (int n = 0; n < 2200; n++) begin
      @(negedge clk);
      if (ss_s[1] && !prev_ss && rise1 < 0) rise1 = cyc;
      if (!ss_s[1] && prev_ss) begin
        falls++;
        if (falls == 2) begin
          fall2      = cyc;
          start_s[1] = 1'b0;
        end
      end
      if (done_s[1]) begin
        done_hi++;
        if (!prev_done) begin
          done_edges++;
          sb_pop(1);
        end
      end
      prev_ss   = ss_s[1];
      prev_done = done_s[1];
    end
    start_s[1] = 1'b0;
    check("b2b_ss_falls", 64'(falls), 64'(2));
    check("b2b_ss_gap", 64'(fall2 - rise1), 64'(9));
    check("b2b_done_pulses", 64'(done_edges), 64'(2));
    check("b2b_done_cycles", 64'(done_hi), 64'(2));
    $display("back2back id=1 gap=%0d dones=%0d rx=%h", fall2 - rise1, done_edges, rx_s[1]);

    run_frame(2, 255, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

    check("sb_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_64spi.md
# m_64spi

SPI master that runs one full-duplex 64-bit frame per `start` request. It is the initiator counterpart of the 64-bit SPI slave: it drives `SS`, `SCLK` and `MOSI`, and captures `MISO`. It sits on the controlling FPGA and connects pin-to-pin with the slave board. Frames are SPI mode 0 (CPOL=0, CPHA=0), MSB first, with `SS` active-low.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `SCLK` half-period. Legal values are 4 to 255. The minimum of 4 covers the slave's synchronizer plus edge detection.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; sampled only in IDLE.
- `tx_data`  in  64  frame to send; captured on the edge that accepts `start`.
- `rx_data`  out  64  last received frame; updated only when `done` pulses.
- `busy`  out  1  high from the accepting edge until `done`.
- `done`  out  1  one-cycle pulse at frame completion.
- `SCLK`  out  1  SPI clock, idles low.
- `MOSI`  out  1  master data out.
- `MISO`  in  1  slave data in; asynchronous to `clk`.
- `SS`  out  1  slave select, active-low.

## Operation
- Reset values (asynchronous, while `reset`=0): `SS`=1, `SCLK`=0, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=0.
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE
  - `start`=1 captures `tx_data` into the shift register, sets `busy`=1 and `SS`=0, drives `MOSI`=tx[63], then enters SETUP.
- SETUP
  - Lasts `CLK_DIV` cycles with `SCLK`=0.
  - Then enters XFER.
- XFER
  - A divider counts `CLK_DIV` cycles per half-period; `SCLK` toggles 128 times, starting with a rise.
  - A 7-bit counter tracks the toggles; at 128 it enters HOLD.
  - On the edge that drives `SCLK` low (end of the high phase), the synchronized `MISO` is shifted into the LSB of the rx shift register.
  - On the same edge, `MOSI` advances to the next tx bit.
  - After the 64th fall, `MOSI` holds its last value.
- MISO path: `MISO` passes through a 2-flop synchronizer before it is sampled.
- HOLD
  - Lasts `CLK_DIV` cycles with `SS`=0 and `SCLK`=0.
  - Then `SS`=1 and the block enters GAP.
- GAP
  - Lasts `CLK_DIV` cycles with `SS`=1.
  - On exit: `rx_data` ← rx shift register, `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while `busy`=1 is ignored; requests are not queued.
- `start` held high continuously: the next frame is accepted on the cycle after `done`.
- Reset mid-frame: all outputs return to their reset values immediately. The partial frame is discarded, `rx_data` is cleared, and `done` does not pulse.
- `tx_data` changes after acceptance do not affect the frame in flight.

## Timing
Edges are counted from E0, the `clk` edge that accepts `start`. Registered outputs change just after the edge.

- `SS` falls after E0. `MOSI`=tx[63] is valid from E0.
- `SCLK` edges:
  - rise k (k=0..63) at E(CLK_DIV·(1+2k));
  - fall k at E(CLK_DIV·(2+2k)).
  - With `CLK_DIV`=4: first rise at E4, last fall at E512.
- Bit k of the receive frame (MSB first) is sampled at fall k, using `MISO` as it was about 2 cycles earlier.
- `SS` rises at E(129·CLK_DIV). Total `SS`-low time is 129·`CLK_DIV` cycles.
- `done` is high for the cycle after E(130·CLK_DIV); `busy` falls at the same edge.
  - With `CLK_DIV`=4: E520.
- Back-to-back frames: minimum `SS`-high gap is `CLK_DIV`+1 cycles.

## Test plan
- **Reset:** assert `reset`=0 mid-XFER → `SS`=1, `SCLK`=0, `busy`=0, `rx_data`=0 within the same cycle; no `done` pulse.
- **Loopback:** tie `MOSI` to `MISO`, `CLK_DIV`=4, `tx_data`=64'hA5A5_0F0F_1234_5678 → `rx_data`=64'hA5A5_0F0F_1234_5678; `done` at E520; exactly 64 `SCLK` rises.
- **Behavioural mode-0 slave:** slave returns 64'h3333333366666666 and records `MOSI` on rising edges; send 64'hDEADBEEF_CAFEF00D → slave holds 64'hDEADBEEF_CAFEF00D and `rx_data`=64'h3333333366666666.
- **Busy lockout:** pulse `start` at E10 and E300 of a frame → ignored; only one `done`; `tx_data` changed at E5 is not transmitted.
- **Back-to-back:** hold `start`=1 for two frames with `CLK_DIV`=8 → second `SS` fall exactly 9 cycles after the first `SS` rise; both `done` pulses are one cycle wide.
- **Divider extremes:** `CLK_DIV`=4 and `CLK_DIV`=255, all-ones then all-zeros loopback → correct `rx_data`; `SCLK` high and low phases are each exactly `CLK_DIV` cycles.
